// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter sharing one BRAM port among NUM_REQ requesters
//   with optional per-requester lock for bounded back-to-back bursts.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_lock    per-requester request and burst-lock bits
//   req_we/addr/wdata     packed per-requester byte enables, word address, write data
//   req_ready             one-hot grant (combinational)
//   rsp_valid/rsp_rdata   one-hot read response one cycle after a read accept
//   bram_en/we/addr/din   BRAM port driven from the granted requester
//   bram_dout             BRAM registered read data
module bram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_lock,
    input  logic [NUM_REQ*NB_COL-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr,
    input  logic [NUM_REQ*NB_COL*COL_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [NB_COL*COL_WIDTH-1:0]           rsp_rdata,
    output logic                                  bram_en,
    output logic [NB_COL-1:0]                     bram_we,
    output logic [ADDR_WIDTH-1:0]                 bram_addr,
    output logic [NB_COL*COL_WIDTH-1:0]           bram_din,
    input  logic [NB_COL*COL_WIDTH-1:0]           bram_dout
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int DW = NB_COL * COL_WIDTH;

    typedef enum logic {FREE, LOCKED} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      owner, owner_n, rr_ptr, rr_n;
    logic [BW-1:0]      burst_cnt, burst_n;
    logic [IW-1:0]      cand, rr_idx, grant;
    logic               rr_found, grant_any, grant_ok;
    logic [NUM_REQ-1:0] rsp_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FREE;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
            rsp_valid <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            burst_cnt <= burst_n;
            rr_ptr    <= rr_n;
            rsp_valid <= rsp_n;
        end
    end

    // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            cand = IW'((int'(rr_ptr) + j) % NUM_REQ);
            if (req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        burst_n   = burst_cnt;
        rr_n      = rr_ptr;
        grant     = rr_idx;
        grant_any = rr_found;
        if (state == LOCKED && req_valid[owner]) begin
            grant     = owner;
            grant_any = 1'b1;
            burst_n   = burst_cnt + 1'b1;
            if (burst_n == BW'(MAX_BURST) || !req_lock[owner]) begin
                state_n = FREE;
                burst_n = '0;
            end
        end else begin
            // An owner that dropped valid loses the lock and competes like everyone else.
            state_n = FREE;
            burst_n = '0;
            if (rr_found) begin
                rr_n = (rr_idx == IW'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
                if (req_lock[rr_idx] && MAX_BURST > 1) begin
                    state_n = LOCKED;
                    owner_n = rr_idx;
                    burst_n = BW'(1);
                end
            end
        end
        grant_ok  = grant_any && !reset;
        req_ready = '0;
        bram_we   = '0;
        bram_addr = '0;
        bram_din  = '0;
        if (grant_ok) begin
            req_ready[grant] = 1'b1;
            bram_we          = req_we[grant*NB_COL +: NB_COL];
            bram_addr        = req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
            bram_din         = req_wdata[grant*DW +: DW];
        end
        bram_en = grant_ok;
        rsp_n   = (grant_ok && bram_we == '0) ? req_ready : '0;
    end

    assign rsp_rdata = (|rsp_valid) ? bram_dout : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed and randomized check of bram_port_arbiter against a behavioural model
module tb_bram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0, req_lock = '0;
    logic [N*NB-1:0] req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, bram_din, bram_dout;
    logic            bram_en;
    logic [NB-1:0]   bram_we;
    logic [AW-1:0]   bram_addr;

    int checks = 0;
    int errors = 0;

    bram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .COL_WIDTH(8), .NB_COL(NB), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Read-first byte-write BRAM attached to the arbiter's port.
    logic [DW-1:0] bram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_en) begin
            bram_dout <= bram_mem[bram_addr];
            for (int b = 0; b < NB; b++)
                if (bram_we[b]) bram_mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
        end
    end

    // Behavioural reference: owner = -1 means nobody holds the lock.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_rr, m_owner, m_cnt, g, pend_idx;
    bit            pend;
    logic [DW-1:0] pend_data;
    logic [NB-1:0] gwe;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gdin;

    always @(negedge clk) begin
        if (reset) begin
            m_rr = 0; m_owner = -1; m_cnt = 0; pend = 0;
            chk("rst_ready", req_ready, 0);
            chk("rst_en", bram_en, 0);
            chk("rst_we", bram_we, 0);
            chk("rst_addr", bram_addr, 0);
            chk("rst_din", bram_din, 0);
            chk("rst_rsp", rsp_valid, 0);
        end else begin
            chk("rsp_valid", rsp_valid, pend ? (64'd1 << pend_idx) : 64'd0);
            if (pend) chk("rsp_rdata", rsp_rdata, pend_data);
            g = -1;
            if (m_owner >= 0 && req_valid[m_owner]) begin
                g = m_owner;
                m_cnt++;
                if (m_cnt == MB || !req_lock[g]) begin m_owner = -1; m_cnt = 0; end
            end else begin
                m_owner = -1; m_cnt = 0;
                for (int j = 0; j < N; j++)
                    if (g < 0 && req_valid[(m_rr + j) % N]) g = (m_rr + j) % N;
                if (g >= 0) begin
                    m_rr = (g + 1) % N;
                    if (req_lock[g] && MB > 1) begin m_owner = g; m_cnt = 1; end
                end
            end
            gwe   = (g >= 0) ? req_we[g*NB +: NB] : '0;
            gaddr = (g >= 0) ? req_addr[g*AW +: AW] : '0;
            gdin  = (g >= 0) ? req_wdata[g*DW +: DW] : '0;
            chk("ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            chk("en", bram_en, g >= 0);
            chk("we", bram_we, gwe);
            chk("addr", bram_addr, gaddr);
            chk("din", bram_din, gdin);
            pend = (g >= 0) && (gwe == 0);
            pend_idx = g;
            if (pend) pend_data = ref_mem[gaddr];
            if (g >= 0)
                for (int b = 0; b < NB; b++)
                    if (gwe[b]) ref_mem[gaddr][b*8 +: 8] = gdin[b*8 +: 8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req_valid = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input bit l, input logic [NB-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_lock[i] = l;
        req_we[i*NB +: NB] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        step(); reset = 1'b1; clr();
        step(); step(); reset = 1'b0;
    endtask

    logic [N-1:0] exp_seq [0:5];
    initial begin
        for (int k = 0; k < (1 << AW); k++) begin
            bram_mem[k] = '0;
            ref_mem[k] = '0;
        end
        bram_dout = '0;
        step(); step(); reset = 1'b0;
        // idle after reset
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t1_en", bram_en, 0);
            chk("t1_ready", req_ready, 0);
            chk("t1_rsp", rsp_valid, 0);
            step();
        end
        // masked write then read-back
        set_req(0, 0, 4'b0011, 10'h10, 32'hA5A5A5A5);
        #1; chk("t2_wr_ready", req_ready, 4'b0001);
        step(); set_req(0, 0, 4'b0000, 10'h10, 32'h0);
        #1; chk("t2_rd_ready", req_ready, 4'b0001);
        step(); clr();
        #1; chk("t2_rsp", rsp_valid, 4'b0001);
        chk("t2_rdata", rsp_rdata, 32'h0000A5A5);
        // plain round-robin rotation
        do_reset();
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < N; i++) set_req(i, 0, 4'b0000, AW'(i), 32'h0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_grant", req_ready, exp_seq[k]);
            chk("t3_en", bram_en, 1);
            step();
        end
        clr();
        // locked burst capped at MAX_BURST, then rr_ptr=3 wraps to req1
        set_req(2, 1, 4'b0000, 10'h2, 32'h0);
        set_req(1, 0, 4'b0000, 10'h1, 32'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_grant", req_ready, (k < 4) ? 4'b0100 : 4'b0010);
            step();
        end
        clr();
        // locked owner drops valid: req3 wins in the same cycle
        set_req(1, 1, 4'b0000, 10'h1, 32'h0);
        #1; chk("t5_g1", req_ready, 4'b0010);
        step(); set_req(3, 0, 4'b0000, 10'h3, 32'h0);
        #1; chk("t5_g2", req_ready, 4'b0010);
        step(); req_valid[1] = 1'b0;
        #1; chk("t5_g3", req_ready, 4'b1000);
        step(); clr(); set_req(0, 0, 4'b0000, 10'h0, 32'h0); set_req(3, 0, 4'b0000, 10'h3, 32'h0);
        #1; chk("t5_free", req_ready, 4'b0001);
        step(); clr();
        // reset right after a read accept drops the response
        set_req(2, 0, 4'b0000, 10'h10, 32'h0);
        #1; chk("t6_accept", req_ready, 4'b0100);
        step(); reset = 1'b1; clr();
        #1; chk("t6_rsp0", rsp_valid, 0);
        step();
        #1; chk("t6_rsp1", rsp_valid, 0);
        step(); reset = 1'b0;
        set_req(3, 0, 4'b0000, 10'h3, 32'h0); set_req(1, 0, 4'b0000, 10'h1, 32'h0);
        #1; chk("t6_first", req_ready, 4'b0010);
        step(); clr();
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            clr();
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) < 6)
                    set_req(i, $urandom_range(0, 9) < 3,
                            ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0,
                            AW'($urandom_range(0, 15)), $urandom);
            step();
        end
        reset = 1'b0; clr();
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
